// File: rtl/pio_sm_array.sv
// Multi-channel PIO sequencer: NUM_SM program counters with wrap windows, forced jumps
// and per-instruction delays, all fetching from one shared instruction memory.
module pio_sm_array #(
  parameter int NUM_SM  = 4,
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INSTR_W-1:0]          data_in,
  input  logic [ADDR_W-1:0]           write_addr,
  input  logic                        write_en,
  input  logic [NUM_SM-1:0]           sm_en,
  input  logic [NUM_SM-1:0]           sm_restart,
  input  logic [NUM_SM*ADDR_W-1:0]    wrap_top,
  input  logic [NUM_SM*ADDR_W-1:0]    wrap_bottom,
  input  logic [NUM_SM*ADDR_W-1:0]    jump,
  input  logic [NUM_SM-1:0]           jump_en,
  output logic [NUM_SM*ADDR_W-1:0]    pc,
  output logic [NUM_SM*INSTR_W-1:0]   instr,
  output logic [NUM_SM-1:0]           issue,
  output logic [NUM_SM-1:0]           stalled
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, EXEC, DELAY} state_t;

  // Memory must clear on reset, so it is a register array rather than block RAM.
  logic [INSTR_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_reg[k] <= '0;
    end else if (write_en) begin
      mem_reg[write_addr] <= data_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SM; gi++) begin : g_sm
      state_t             state_reg;
      logic [ADDR_W-1:0]  pc_reg;
      logic [4:0]         cnt_reg;
      logic [INSTR_W-1:0] cur_word;
      logic [2:0]         opcode;
      logic [4:0]         delay;
      logic [ADDR_W-1:0]  wt, wb, jt, pc_next;

      assign cur_word = mem_reg[pc_reg];
      assign opcode   = cur_word[15:13];
      assign delay    = cur_word[12:8];
      assign wt       = wrap_top[gi*ADDR_W +: ADDR_W];
      assign wb       = wrap_bottom[gi*ADDR_W +: ADDR_W];
      assign jt       = jump[gi*ADDR_W +: ADDR_W];

      // JMP bypasses the wrap window; otherwise wrap only when the current PC equals wrap_top.
      always_comb begin
        pc_next = pc_reg + ADDR_W'(1);
        if (opcode == 3'b000)  pc_next = cur_word[ADDR_W-1:0];
        else if (pc_reg == wt) pc_next = wb;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= IDLE;
          pc_reg    <= '0;
          cnt_reg   <= '0;
        end else if (sm_restart[gi]) begin
          pc_reg    <= wb;
          cnt_reg   <= '0;
          state_reg <= sm_en[gi] ? EXEC : IDLE;
        end else if (jump_en[gi] && sm_en[gi]) begin
          pc_reg    <= jt;
          cnt_reg   <= '0;
          state_reg <= EXEC;
        end else if (!sm_en[gi]) begin
          state_reg <= IDLE;
        end else begin
          case (state_reg)
            IDLE: state_reg <= (cnt_reg != '0) ? DELAY : EXEC;
            EXEC: begin
              pc_reg <= pc_next;
              if (delay != '0) begin
                cnt_reg   <= delay;
                state_reg <= DELAY;
              end
            end
            DELAY: begin
              cnt_reg <= cnt_reg - 5'd1;
              if (cnt_reg <= 5'd1) state_reg <= EXEC;
            end
            default: state_reg <= IDLE;
          endcase
        end
      end

      assign pc[gi*ADDR_W +: ADDR_W]       = pc_reg;
      assign instr[gi*INSTR_W +: INSTR_W]  = cur_word;
      assign issue[gi]                     = (state_reg == EXEC);
      assign stalled[gi]                   = (state_reg == DELAY);
    end
  endgenerate

endmodule

// File: doc/pio_sm_array.md
Name: pio_sm_array

Overview:
- Parametrised multi-channel PIO sequencer; successor to the single program-counter, instruction-regfile and FSM trio.
- NUM_SM independent state machines share one instruction memory.
- Each SM has its own PC, wrap window, forced-jump port and instruction delay counter.
- Feeds the per-SM execute units: issues one instruction per SM per active cycle.

Parameters:
- NUM_SM, 4, number of state machines (1..8).
- ADDR_W, 5, instruction address width; memory depth = 2**ADDR_W.
- INSTR_W, 16, instruction width; fixed field layout below requires INSTR_W >= 16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  INSTR_W  instruction memory write data.
- write_addr  in  ADDR_W  instruction memory write address.
- write_en  in  1  memory write strobe.
- sm_en  in  NUM_SM  per-SM run enable.
- sm_restart  in  NUM_SM  per-SM synchronous restart pulse.
- wrap_top  in  NUM_SM*ADDR_W  packed per-SM wrap top; SM i uses bits [i*ADDR_W +: ADDR_W].
- wrap_bottom  in  NUM_SM*ADDR_W  packed per-SM wrap bottom.
- jump  in  NUM_SM*ADDR_W  packed per-SM forced-jump target.
- jump_en  in  NUM_SM  per-SM forced-jump strobe.
- pc  out  NUM_SM*ADDR_W  packed per-SM program counter (registered).
- instr  out  NUM_SM*INSTR_W  packed per-SM current instruction, mem[pc_i] (combinational read).
- issue  out  NUM_SM  per-SM execute strobe (combinational from state).
- stalled  out  NUM_SM  per-SM high while in DELAY.

Behaviour:
- Instruction fields:
  - [15:13] opcode; 3'b000 = JMP.
  - [12:8] delay count d.
  - [ADDR_W-1:0] JMP target.
  - All other opcodes are opaque here and simply advance the PC.
- Reset (rst low, async):
  - All memory words = 0.
  - All PCs = 0, all delay counters = 0, all SMs in IDLE.
  - issue = 0, stalled = 0.
- Memory write: on a clk edge with write_en, mem[write_addr] <= data_in. A read of the same address in that cycle returns the old word; the new word is visible from the next cycle.
- Per-SM states:
  - IDLE: sm_en = 0; PC held; issue = 0.
  - EXEC: issue = 1; instr = mem[pc].
  - DELAY: issue = 0; stalled = 1.
- Transitions, in priority order:
  1. sm_restart=1 (any state): pc <= wrap_bottom, cnt <= 0, next state EXEC if sm_en else IDLE.
  2. jump_en=1 and sm_en=1 (any state, aborts DELAY): pc <= jump, cnt <= 0, next state EXEC.
  3. sm_en=0: next state IDLE; PC and cnt frozen. Re-enabling from a frozen DELAY resumes DELAY with the remaining count.
  4. IDLE with sm_en=1: next state EXEC (or DELAY if cnt != 0); PC unchanged.
  5. EXEC:
     - pc <= JMP target if opcode is JMP.
     - Else pc <= wrap_bottom if pc == wrap_top.
     - Else pc <= pc+1, modulo 2**ADDR_W.
     - If d != 0: cnt <= d, next state DELAY; else stay EXEC.
  6. DELAY: cnt <= cnt-1; when cnt == 1, next state EXEC.
- Timing: an instruction with delay d occupies exactly 1+d cycles; the next issue follows on cycle 1+d.
- Wrap rules:
  - JMP ignores the wrap window.
  - The wrap check compares the current PC only.
  - wrap_top < wrap_bottom is legal: wrap is still taken at wrap_top.
  - A PC outside the window increments with natural rollover until it hits wrap_top.
- SMs are fully independent; all may read the same address in the same cycle.
- Reset asserted mid-DELAY or mid-write: immediate return to reset values; no partial state survives.

Test Plan:
- Wrap: load mem[0..3] with opcode 3'b001, d=0; SM0 wrap_bottom=1, wrap_top=3, sm_en=1 -> pc sequence 0,1,2,3,1,2,3,1; issue high every cycle.
- Delay: mem[0] = 16'h2300 (opcode 001, d=3), mem[1] = 16'h2000 -> issue at cycles 0 and 4; stalled high cycles 1-3; pc = 1 from cycle 1.
- JMP vs forced jump: mem[2] = JMP target 7 -> pc 2 then 7 ignoring wrap_top=4. jump_en with jump=5 during a d=4 delay -> next cycle pc = 5, issue = 1, stalled = 0.
- Restart priority: sm_restart and jump_en in the same cycle with wrap_bottom=6, jump=9 -> pc = 6. With sm_en=0 -> state IDLE, issue = 0.
- Multi-SM: SM0 and SM1 run different wraps (0-1 and 8-10) simultaneously while SM2 is disabled -> independent pc sequences; SM2 pc frozen, issue = 0.
- Write/reset: write mem[1] = 16'h2000 while SM0 sits at pc=1 -> instr shows the old word that cycle, the new word next cycle. Assert rst low mid-delay -> pc = 0, stalled = 0, mem[1] reads 0.
